la_capture_sampler: RTL and testbench
=====================================

Name: la_capture_sampler

Overview:
- Consumer end of the sampling clock-enable produced by the analyzer's prescaler.
- On each `ce` strobe it samples the synchronized probe channels into an internal circular sample memory.
- It keeps a programmable pre-trigger window, waits for a mask/value trigger, then captures a programmable post-trigger window.
- Afterwards it streams the captured record, oldest first, over a valid/ready interface to the host-transfer logic.

Parameters:
- CHANNELS, 8, number of probe channels (sample word width).
- DEPTH_LOG2, 10, sample memory depth = 2^DEPTH_LOG2 words.
- SYNC_STAGES, 2, flip-flop stages on `ch_in` (minimum 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ce  in  1  sample strobe from prescaler; one sample per clk cycle with ce=1.
- ch_in  in  CHANNELS  asynchronous probe inputs.
- arm  in  1  single-cycle start; honoured only in IDLE.
- abort  in  1  cancel capture or readout from any state.
- pre_count  in  DEPTH_LOG2+1  requested pre-trigger samples; latched on arm.
- post_count  in  DEPTH_LOG2+1  post-trigger samples including the trigger sample; latched on arm.
- trig_mask  in  CHANNELS  1 = channel participates in trigger; latched on arm.
- trig_value  in  CHANNELS  required level per masked channel; latched on arm.
- out_data  out  CHANNELS  sample word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts when out_valid and out_ready are both high.
- out_last  out  1  high with the final word of the record.
- busy  out  1  state != IDLE.
- triggered  out  1  trigger seen in the current or most recent capture; cleared on arm.

Behaviour:
- Reset: state IDLE; out_valid, out_last, busy, triggered = 0; out_data = 0; pointers and counters = 0; memory contents undefined.
- Sampling latency: `ch_in` passes through SYNC_STAGES flops; a sample written on a ce cycle is the value at the sync output on that edge. `ce` is not delayed.
- Latch rules on arm (in IDLE):
  - post_eff = max(post_count, 1), then clamped to DEPTH.
  - pre_eff = min(pre_count, DEPTH - post_eff).
  - Mask, value, pre_eff and post_eff are latched.
  - Trigger flag is cleared.
  - Next state is PRE, or ARMED if pre_eff = 0.
- PRE:
  - Each ce writes the sample at wr_ptr, then wr_ptr increments modulo DEPTH.
  - After pre_eff writes, move to ARMED.
  - Trigger is not evaluated in PRE.
- ARMED:
  - Each ce evaluates hit = ((sample ^ trig_value) & trig_mask) == 0.
  - No hit: write sample, stay in ARMED. Writes wrap freely; the oldest words are overwritten.
  - Hit: write sample (counts as post sample 1), set triggered, go to POST. If post_eff = 1, go directly to READOUT.
  - trig_mask = 0 triggers on the first ARMED sample.
- POST:
  - Each ce writes a sample; after post_eff total post samples, go to READOUT.
  - ce is ignored after the last post write.
- READOUT:
  - Record length N = pre_eff + post_eff.
  - Start address = wr_ptr - N (mod DEPTH).
  - Words are streamed in address order.
  - Memory is read with 1-cycle latency. The first out_valid rises no later than 2 cycles after entering READOUT.
  - out_data, out_valid and out_last are held stable while out_valid=1 and out_ready=0.
  - Back-to-back transfer at one word per cycle is sustained when out_ready stays high.
  - out_last=1 only on word N. After it is accepted: out_valid=0 next cycle, state returns to IDLE.
- Simultaneous events:
  - abort has priority over everything except rst. Next cycle: IDLE, out_valid=0, out_last=0; triggered keeps its value.
  - arm and abort in the same IDLE cycle: stay in IDLE.
  - arm outside IDLE is ignored.
  - ce during READOUT or IDLE is ignored.
- rst mid-capture or mid-readout: immediate IDLE with the reset values above; a partial record is never output.

Optional Feature:
- Macro: LA_CAPTURE_EDGE_TRIG_EN.
- When defined:
  - Adds input `trig_edge` (CHANNELS), latched on arm.
  - For channels with trig_edge=1, the match requires sample == trig_value and previous sample != trig_value (i.e. a transition into the level).
  - "Previous sample" = last sample taken on a ce in PRE or ARMED. On the first ARMED sample with pre_eff = 0, there is no previous sample and edge channels do not match.
- When undefined: port absent; pure level trigger as above.

Test Plan:
- Reset/idle: assert rst 3 cycles with ce toggling → busy=0, out_valid=0, triggered=0; no state change without arm.
- Basic capture: DEPTH_LOG2=4, ce every 4th clk, pre_count=3, post_count=4, mask=0x01, value=0x01, ch_in counter with bit0 set at sample 6 → 7 words out, oldest first, word 4 is trigger sample, out_last on word 7, then IDLE.
- Clamping: DEPTH=16, pre_count=20, post_count=0 → post_eff=1, pre_eff=15, 16 words out; trigger word last.
- Wrap-around: pre_count=4, no trigger for 40 samples, then hit, post_count=2 → output = 4 samples immediately before the trigger, then the trigger sample and the next sample.
- Backpressure: toggle out_ready pseudo-randomly during readout → no word duplicated or dropped; out_data stable while stalled; exactly N handshakes.
- Abort/reset mid-operation: abort in POST → IDLE next cycle, out_valid never asserts. Separately, rst on 3rd readout word → all outputs reset next cycle. Re-arm afterwards → capture works normally.

Source files
------------

// File: rtl/la_capture_sampler_if.sv
// Readout stream of the capture sampler: one sample word per valid/ready handshake,
// with out_last marking the final word of a record.
interface la_capture_sampler_if #(
    parameter int CHANNELS = 8
) ();
    logic [CHANNELS-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/la_capture_sampler.sv
// Logic-analyzer capture core: pre-trigger ring buffer, mask/value trigger, post window, oldest-first readout.
// Defining LA_CAPTURE_EDGE_TRIG_EN adds the trig_edge input for per-channel transition triggering.
module la_capture_sampler #(
    parameter int CHANNELS    = 8,
    parameter int DEPTH_LOG2  = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [CHANNELS-1:0]   ch_in,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DEPTH_LOG2:0]   pre_count,
    input  logic [DEPTH_LOG2:0]   post_count,
    input  logic [CHANNELS-1:0]   trig_mask,
    input  logic [CHANNELS-1:0]   trig_value,
`ifdef LA_CAPTURE_EDGE_TRIG_EN
    input  logic [CHANNELS-1:0]   trig_edge,
`endif
    la_capture_sampler_if.master  out_if,
    output logic                  busy,
    output logic                  triggered
);

    localparam int                    CW       = DEPTH_LOG2 + 1;
    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0]         DEPTH_W  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CW-1:0]         ONE      = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_READOUT
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
    logic [CHANNELS-1:0]             w_sample;

    logic [CHANNELS-1:0]             r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]           r_wr_ptr;
    logic [DEPTH_LOG2-1:0]           w_wr_ptr_next;
    logic [DEPTH_LOG2-1:0]           r_rd_addr;

    logic [CW-1:0]                   r_cnt;
    logic [CW-1:0]                   w_cnt_next;
    logic [CW-1:0]                   r_pre_eff;
    logic [CW-1:0]                   r_post_eff;
    logic [CW-1:0]                   r_len;
    logic [CW-1:0]                   r_issued;
    logic [CW-1:0]                   w_pre_eff;
    logic [CW-1:0]                   w_post_eff;

    logic [CHANNELS-1:0]             r_trig_mask;
    logic [CHANNELS-1:0]             r_trig_value;
    logic [CHANNELS-1:0]             w_bit_ok;
    logic                            w_hit;
    logic                            r_triggered;

    logic [CHANNELS-1:0]             r_out_data;
    logic                            r_out_valid;
    logic                            r_out_last;

    logic                            w_wr_en;
    logic                            w_latch;
    logic                            w_set_trig;
    logic                            w_load;
    logic                            w_enter_ro;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ch_in};
        end
    end

    assign w_sample = r_sync[SYNC_STAGES-1];

    // post window is at least the trigger sample; pre window takes what is left of the memory
    assign w_post_eff = (post_count == '0)    ? ONE     :
                        (post_count > DEPTH_W) ? DEPTH_W : post_count;
    assign w_pre_eff  = (pre_count > (DEPTH_W - w_post_eff)) ? (DEPTH_W - w_post_eff) : pre_count;

    genvar gi;
`ifdef LA_CAPTURE_EDGE_TRIG_EN
    logic [CHANNELS-1:0] r_trig_edge;
    logic [CHANNELS-1:0] r_prev_sample;
    logic                r_prev_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_edge   <= '0;
            r_prev_sample <= '0;
            r_prev_valid  <= 1'b0;
        end else if (w_latch) begin
            r_trig_edge   <= trig_edge;
            r_prev_valid  <= 1'b0;
        end else if (w_wr_en && (r_state == S_PRE || r_state == S_ARMED)) begin
            r_prev_sample <= w_sample;
            r_prev_valid  <= 1'b1;
        end
    end

    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_trig
            assign w_bit_ok[gi] = (w_sample[gi] == r_trig_value[gi]) &&
                                  (!r_trig_edge[gi] ||
                                   (r_prev_valid && (r_prev_sample[gi] != r_trig_value[gi])));
        end
    endgenerate
`else
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_trig
            assign w_bit_ok[gi] = (w_sample[gi] == r_trig_value[gi]);
        end
    endgenerate
`endif

    assign w_hit = &(w_bit_ok | ~r_trig_mask);

    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_latch      = 1'b0;
        w_set_trig   = 1'b0;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_latch      = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = (w_pre_eff == '0) ? S_ARMED : S_PRE;
                end
            end
            S_PRE: begin
                if (ce) begin
                    w_wr_en = 1'b1;
                    if (r_cnt + ONE == r_pre_eff) begin
                        w_cnt_next   = '0;
                        w_state_next = S_ARMED;
                    end else begin
                        w_cnt_next   = r_cnt + ONE;
                    end
                end
            end
            S_ARMED: begin
                if (ce) begin
                    w_wr_en = 1'b1;
                    if (w_hit) begin
                        w_set_trig   = 1'b1;
                        w_cnt_next   = ONE;
                        w_state_next = (r_post_eff == ONE) ? S_READOUT : S_POST;
                    end
                end
            end
            S_POST: begin
                if (ce) begin
                    w_wr_en    = 1'b1;
                    w_cnt_next = r_cnt + ONE;
                    if (r_cnt + ONE == r_post_eff) begin
                        w_state_next = S_READOUT;
                    end
                end
            end
            S_READOUT: begin
                if (r_out_valid && out_if.out_ready && r_out_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (abort) begin
            w_state_next = S_IDLE;
            w_wr_en      = 1'b0;
            w_latch      = 1'b0;
            w_set_trig   = 1'b0;
        end
    end

    assign w_wr_ptr_next = w_wr_en ? (r_wr_ptr + ADDR_ONE) : r_wr_ptr;
    assign w_enter_ro    = (r_state != S_READOUT) && (w_state_next == S_READOUT);
    // fetch the next word whenever the output register is empty or being drained this cycle
    assign w_load        = (r_state == S_READOUT) && !abort && (r_issued != r_len) &&
                           (!r_out_valid || out_if.out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wr_ptr     <= '0;
            r_rd_addr    <= '0;
            r_issued     <= '0;
            r_pre_eff    <= '0;
            r_post_eff   <= '0;
            r_len        <= '0;
            r_trig_mask  <= '0;
            r_trig_value <= '0;
            r_triggered  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_wr_ptr <= w_wr_ptr_next;
            if (w_latch) begin
                r_pre_eff    <= w_pre_eff;
                r_post_eff   <= w_post_eff;
                r_len        <= w_pre_eff + w_post_eff;
                r_trig_mask  <= trig_mask;
                r_trig_value <= trig_value;
                r_triggered  <= 1'b0;
            end
            if (w_set_trig) begin
                r_triggered <= 1'b1;
            end
            if (w_enter_ro) begin
                r_rd_addr <= w_wr_ptr_next - r_len[DEPTH_LOG2-1:0];
                r_issued  <= '0;
            end
            if (abort) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_last  <= (r_issued + ONE == r_len);
                r_rd_addr   <= r_rd_addr + ADDR_ONE;
                r_issued    <= r_issued + ONE;
            end else if (r_out_valid && out_if.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data <= '0;
        end else if (w_load) begin
            r_out_data <= r_mem[r_rd_addr];
        end
    end

    assign out_if.out_data  = r_out_data;
    assign out_if.out_valid = r_out_valid;
    assign out_if.out_last  = r_out_last;
    assign busy             = (r_state != S_IDLE);
    assign triggered        = r_triggered;

endmodule

// File: tb/tb_la_capture_sampler.sv
// Directed bench for la_capture_sampler: expected records are queued at stimulus time and
// checked by an independent monitor on the readout stream.
module tb_la_capture_sampler;
    localparam int CH = 8;
    localparam int DL = 4;

    typedef struct packed {
        logic [CH-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [CH-1:0] ch_in = '0;
    logic [DL:0]   pre_count = '0;
    logic [DL:0]   post_count = '0;
    logic [CH-1:0] trig_mask = '0;
    logic [CH-1:0] trig_value = '0;
`ifdef LA_CAPTURE_EDGE_TRIG_EN
    logic [CH-1:0] trig_edge = '0;
`endif
    logic          busy;
    logic          triggered;

    logic          rand_en = 1'b0;
    logic          ready_force = 1'b1;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            mon_pops = 0;
    logic          mon_stall = 1'b0;
    logic [CH-1:0] mon_held = '0;

    la_capture_sampler_if #(.CHANNELS(CH)) out_if ();

    la_capture_sampler #(
        .CHANNELS   (CH),
        .DEPTH_LOG2 (DL),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .ch_in     (ch_in),
        .arm       (arm),
        .abort     (abort),
        .pre_count (pre_count),
        .post_count(post_count),
        .trig_mask (trig_mask),
        .trig_value(trig_value),
`ifdef LA_CAPTURE_EDGE_TRIG_EN
        .trig_edge (trig_edge),
`endif
        .out_if    (out_if),
        .busy      (busy),
        .triggered (triggered)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic push1(input logic [CH-1:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // ch_in is held three clocks ahead of the ce pulse so the synchronizer output has settled
    task automatic do_sample(input logic [CH-1:0] v);
        ch_in = v;
        repeat (3) @(posedge clk);
        #1 ce = 1'b1;
        @(posedge clk);
        #1 ce = 1'b0;
    endtask

    task automatic arm_cfg(input int pre, input int post, input logic [CH-1:0] m, input logic [CH-1:0] v);
        pre_count  = (DL+1)'(pre);
        post_count = (DL+1)'(post);
        trig_mask  = m;
        trig_value = v;
        arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_if.out_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // monitor: stall stability, spurious words, and in-order comparison against the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_stall) begin
                check("stall_valid", 32'(out_if.out_valid), 32'd1);
                check("stall_data", 32'(out_if.out_data), 32'(mon_held));
            end
            if (out_if.out_valid && !rst && !abort) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_word: got data 0x%02h valid 1 required no word", out_if.out_data);
                end else if (out_if.out_ready) begin
                    e = exp_q.pop_front();
                    mon_pops++;
                    $display("word %0d data=0x%02h last=%0b", mon_pops, out_if.out_data, out_if.out_last);
                    check("word_data", 32'(out_if.out_data), 32'(e.data));
                    check("word_last", 32'(out_if.out_last), 32'(e.last));
                end
            end
            mon_stall = out_if.out_valid && !out_if.out_ready && !rst && !abort;
            mon_held  = out_if.out_data;
        end
    end

    initial begin
        int base;
        int n;
        out_if.out_ready = 1'b1;

        // reset with ce toggling
        repeat (3) begin
            @(posedge clk);
            #1 ce = ~ce;
        end
        rst = 1'b0;
        ce  = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_if.out_valid), 32'd0);
        check("rst_last", 32'(out_if.out_last), 32'd0);
        check("rst_trig", 32'(triggered), 32'd0);
        check("rst_data", 32'(out_if.out_data), 32'd0);
        do_sample(8'h55);
        do_sample(8'h01);
        check("idle_no_arm", 32'(busy), 32'd0);

        // basic capture: pre 3, post 4, trigger on bit0
        begin
            logic [CH-1:0] s1 [9] = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0D, 8'h0E, 8'h10, 8'h12};
            logic [CH-1:0] e1 [7] = '{8'h06, 8'h08, 8'h0A, 8'h0D, 8'h0E, 8'h10, 8'h12};
            for (int i = 0; i < 7; i++) push1(e1[i], i == 6);
            arm_cfg(3, 4, 8'h01, 8'h01);
            check("basic_busy", 32'(busy), 32'd1);
            for (int i = 0; i < 9; i++) do_sample(s1[i]);
            do_sample(8'hFF);
            wait_idle("basic");
            check("basic_trig", 32'(triggered), 32'd1);
        end

        // clamping: post 0 -> 1, pre 20 -> 15; 0xAA in PRE must not trigger
        for (int i = 2; i <= 15; i++) push1((i == 5) ? 8'hAA : 8'(i), 1'b0);
        push1(8'h20, 1'b0);
        push1(8'hAA, 1'b1);
        arm_cfg(20, 0, 8'hFF, 8'hAA);
        for (int i = 1; i <= 15; i++) do_sample((i == 5) ? 8'hAA : 8'(i));
        check("clamp_no_pre_trig", 32'(triggered), 32'd0);
        do_sample(8'h20);
        do_sample(8'hAA);
        wait_idle("clamp");

        // wrap-around: 40 untriggered ARMED samples overwrite the ring
        for (int i = 8'h29; i <= 8'h2C; i++) push1(8'(i), 1'b0);
        push1(8'h81, 1'b0);
        push1(8'h82, 1'b1);
        arm_cfg(4, 2, 8'h80, 8'h80);
        for (int i = 1; i <= 8'h2C; i++) do_sample(8'(i));
        do_sample(8'h81);
        do_sample(8'h82);
        wait_idle("wrap");

        // backpressure with mask 0 (first ARMED sample triggers)
        for (int i = 8'h31; i <= 8'h38; i++) push1(8'(i), i == 8'h38);
        base = mon_pops;
        arm_cfg(5, 3, 8'h00, 8'h00);
        for (int i = 8'h31; i <= 8'h37; i++) do_sample(8'(i));
        rand_en = 1'b1;
        do_sample(8'h38);
        wait_idle("bp");
        rand_en = 1'b0;
        check("bp_handshakes", 32'(mon_pops - base), 32'd8);

        // abort in POST: no word may appear
        arm_cfg(2, 4, 8'h01, 8'h01);
        do_sample(8'h02);
        do_sample(8'h04);
        do_sample(8'h05);
        do_sample(8'h06);
        check("abort_pre_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_if.out_valid), 32'd0);
        check("abort_trig_kept", 32'(triggered), 32'd1);
        do_sample(8'h07);
        do_sample(8'h09);
        check("abort_ce_idle", 32'(busy), 32'd0);
        arm = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
        abort = 1'b0;
        check("arm_abort_busy", 32'(busy), 32'd0);
        check("arm_abort_trig", 32'(triggered), 32'd1);

        // rst while the third readout word is presented
        for (int i = 8'h41; i <= 8'h45; i++) push1(8'(i), i == 8'h45);
        base = mon_pops;
        arm_cfg(3, 2, 8'h00, 8'h00);
        for (int i = 8'h41; i <= 8'h45; i++) do_sample(8'(i));
        n = 0;
        while ((mon_pops - base) < 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_word3_reached", 32'((mon_pops - base) >= 2), 32'd1);
        check("rst_word3_valid", 32'(out_if.out_valid), 32'd1);
        rst = 1'b1;
        ready_force = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(out_if.out_valid), 32'd0);
        check("midrst_last", 32'(out_if.out_last), 32'd0);
        check("midrst_data", 32'(out_if.out_data), 32'd0);
        check("midrst_trig", 32'(triggered), 32'd0);
        rst = 1'b0;
        ready_force = 1'b1;
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1 check("midrst_quiet", 32'(out_if.out_valid), 32'd0);

        // re-arm after reset: post 1 goes straight to readout
        push1(8'h22, 1'b0);
        push1(8'h77, 1'b1);
        arm_cfg(1, 1, 8'hFF, 8'h77);
        do_sample(8'h11);
        do_sample(8'h22);
        do_sample(8'h77);
        wait_idle("rearm");
        check("rearm_trig", 32'(triggered), 32'd1);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
